clock_run_controller: RTL and testbench

Run/step/halt controller for the processor's slow clock. It derives a programmable slow clock and a one-cycle CPU clock-enable from `Fast_Clock`. It also sequences execution from board buttons: free-run, single-step, and halt on request from the processor. It sits between the board inputs and the processor core, and replaces the fixed free-running divider for debug builds.

---
 rtl/clock_run_controller.sv | 137 +++++++++++++
 tb/tb_clock_run_controller.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_run_controller.sv
// Run/step/halt sequencer for the processor's slow clock: a programmable divider
// on Fast_Clock plus button-driven free-run, single-step and halt-on-request.
module clock_run_controller #(
  parameter int unsigned DEFAULT_DIV = 2500,
  parameter int unsigned DIV_WIDTH   = 16
) (
  input  logic                 Fast_Clock,
  input  logic                 Reset,
  input  logic                 Run_Button,
  input  logic                 Step_Button,
  input  logic                 Halt_Request,
  input  logic                 Div_Load,
  input  logic [DIV_WIDTH-1:0] Div_Value,
  output logic                 Slow_Clock,
  output logic                 Cpu_Enable,
  output logic [1:0]           State,
  output logic [31:0]          Cycle_Count
);

  typedef enum logic [1:0] {
    HALTED = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           run_sync_q, run_sync_d;
  logic [1:0]           step_sync_q, step_sync_d;
  logic                 run_prev_q, run_prev_d;
  logic                 step_prev_q, step_prev_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic                 slow_q, slow_d;
  logic                 cpu_en_q, cpu_en_d;
  logic [31:0]          cycle_count_q, cycle_count_d;
  logic                 pend_q, pend_d;

  logic run_edge;
  logic step_edge;
  logic active;
  logic tick;
  logic rise_tick;

  always_comb begin
    run_sync_d    = {run_sync_q[0], Run_Button};
    step_sync_d   = {step_sync_q[0], Step_Button};
    run_prev_d    = run_sync_q[1];
    step_prev_d   = step_sync_q[1];
    run_edge      = run_sync_q[1] & ~run_prev_q;
    step_edge     = step_sync_q[1] & ~step_prev_q;

    // ">=" lets a smaller divider loaded mid-period end the half-period at once
    active        = (state_q != HALTED);
    tick          = active && (count_q >= div_q);
    rise_tick     = tick && !slow_q;

    div_d         = Div_Load ? Div_Value : div_q;
    count_d       = count_q;
    slow_d        = slow_q;
    cpu_en_d      = rise_tick;
    cycle_count_d = cycle_count_q + 32'(rise_tick);
    state_d       = state_q;
    pend_d        = pend_q;

    if (tick) begin
      count_d = '0;
      slow_d  = ~slow_q;
    end else if (active) begin
      count_d = count_q + 1'b1;
    end else begin
      count_d = '0;
      slow_d  = 1'b1;
    end

    // Halts only complete on a rising tick so Slow_Clock always rests high
    case (state_q)
      HALTED: begin
        if (run_edge && !Halt_Request) begin
          state_d = RUN;
        end else if (step_edge) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (rise_tick && pend_q) begin
          state_d = HALTED;
          pend_d  = 1'b0;
        end else if (run_edge || Halt_Request) begin
          pend_d  = 1'b1;
        end
      end
      STEP: begin
        if (rise_tick) begin
          state_d = HALTED;
        end
      end
      default: begin
        state_d = HALTED;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= HALTED;
      run_sync_q    <= '0;
      step_sync_q   <= '0;
      run_prev_q    <= 1'b0;
      step_prev_q   <= 1'b0;
      div_q         <= DIV_WIDTH'(DEFAULT_DIV);
      count_q       <= '0;
      slow_q        <= 1'b1;
      cpu_en_q      <= 1'b0;
      cycle_count_q <= '0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_sync_q    <= run_sync_d;
      step_sync_q   <= step_sync_d;
      run_prev_q    <= run_prev_d;
      step_prev_q   <= step_prev_d;
      div_q         <= div_d;
      count_q       <= count_d;
      slow_q        <= slow_d;
      cpu_en_q      <= cpu_en_d;
      cycle_count_q <= cycle_count_d;
      pend_q        <= pend_d;
    end
  end

  assign State       = state_q;
  assign Slow_Clock  = slow_q;
  assign Cpu_Enable  = cpu_en_q;
  assign Cycle_Count = cycle_count_q;

endmodule

// File: tb/tb_clock_run_controller.sv
// Bench for clock_run_controller: directed and randomized button/halt/divider
// sequences checked each cycle against a phase-based timing model.
module tb_clock_run_controller;

  localparam int DIV_W  = 16;
  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic             Fast_Clock = 1'b0;
  logic             Reset;
  logic             Run_Button;
  logic             Step_Button;
  logic             Halt_Request;
  logic             Div_Load;
  logic [DIV_W-1:0] Div_Value;
  logic             Slow_Clock;
  logic             Cpu_Enable;
  logic [1:0]       State;
  logic [31:0]      Cycle_Count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: mode, entry edge and divider fix the slow-clock phase of every edge
  int          g_edge;
  int          m_mode;
  int          m_entry;
  int          m_div;
  int          m_pend_edge;
  int          m_run_at;
  int          m_step_at;
  logic [31:0] m_count;

  always #5 Fast_Clock = ~Fast_Clock;

  clock_run_controller #(
    .DEFAULT_DIV(2500),
    .DIV_WIDTH  (DIV_W)
  ) dut (
    .Fast_Clock  (Fast_Clock),
    .Reset       (Reset),
    .Run_Button  (Run_Button),
    .Step_Button (Step_Button),
    .Halt_Request(Halt_Request),
    .Div_Load    (Div_Load),
    .Div_Value   (Div_Value),
    .Slow_Clock  (Slow_Clock),
    .Cpu_Enable  (Cpu_Enable),
    .State       (State),
    .Cycle_Count (Cycle_Count)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, observed, expected, g_edge);
    end
  endtask

  task automatic model_reset();
    m_mode      = M_HALT;
    m_entry     = 0;
    m_div       = 2500;
    m_pend_edge = -1;
    m_run_at    = -1;
    m_step_at   = -1;
    m_count     = 32'd0;
  endtask

  task automatic async_reset(input string tag);
    Reset = 1'b1;
    #2;
    check_output({tag, ".state"}, 32'(State), 32'd0);
    check_output({tag, ".slow"}, 32'(Slow_Clock), 32'd1);
    check_output({tag, ".cpu_en"}, 32'(Cpu_Enable), 32'd0);
    check_output({tag, ".count"}, Cycle_Count, 32'd0);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic tick(input string tag);
    logic hr;
    logic exp_cpu;
    logic exp_slow;
    int   pre;
    int   n;
    int   per;
    hr = Halt_Request;
    @(posedge Fast_Clock);
    #1;
    g_edge++;
    pre     = m_mode;
    exp_cpu = 1'b0;
    per     = 2 * (m_div + 1);
    if (pre == M_HALT) begin
      if (g_edge == m_run_at && !hr) begin
        m_mode  = M_RUN;
        m_entry = g_edge;
      end else if (g_edge == m_step_at) begin
        m_mode  = M_STEP;
        m_entry = g_edge;
      end
    end else begin
      n = g_edge - m_entry;
      if (n % per == 0) begin
        exp_cpu = 1'b1;
        m_count++;
        if (pre == M_STEP || (m_pend_edge >= 0 && m_pend_edge < g_edge)) begin
          m_mode      = M_HALT;
          m_pend_edge = -1;
        end
      end
      if (m_mode == M_RUN && m_pend_edge < 0 && (g_edge == m_run_at || hr)) m_pend_edge = g_edge;
    end
    if (m_mode == M_HALT) begin
      exp_slow = 1'b1;
    end else begin
      n = g_edge - m_entry;
      exp_slow = ((n % per) < (m_div + 1));
    end
    check_output({tag, ".state"}, 32'(State), 32'(m_mode));
    check_output({tag, ".slow"}, 32'(Slow_Clock), 32'(exp_slow));
    check_output({tag, ".cpu_en"}, 32'(Cpu_Enable), 32'(exp_cpu));
    check_output({tag, ".count"}, Cycle_Count, m_count);
  endtask

  task automatic apply_stimulus(input logic run, input logic step, input string tag);
    if (run) begin
      Run_Button = 1'b1;
      m_run_at   = g_edge + 3;
    end
    if (step) begin
      Step_Button = 1'b1;
      m_step_at   = g_edge + 3;
    end
    repeat (4) tick(tag);
    Run_Button  = 1'b0;
    Step_Button = 1'b0;
    repeat (2) tick(tag);
  endtask

  task automatic load_div(input int v);
    Div_Load  = 1'b1;
    Div_Value = DIV_W'(v);
    tick("load_div");
    Div_Load  = 1'b0;
    m_div     = v;
  endtask

  task automatic wait_halt(input int limit, input string tag);
    int k;
    k = 0;
    while (State !== 2'b00 && k < limit) begin
      tick(tag);
      k++;
    end
    check_output({tag, ".halted"}, 32'(State), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    int h;
    int cnt;
    int d;
    Reset        = 1'b0;
    Run_Button   = 1'b0;
    Step_Button  = 1'b0;
    Halt_Request = 1'b0;
    Div_Load     = 1'b0;
    Div_Value    = '0;
    g_edge       = 0;
    model_reset();
    #1;
    async_reset("reset_init");
    repeat (3) tick("idle");

    // Free run with DIV=3: period 8, ten enables
    load_div(3);
    apply_stimulus(1'b1, 1'b0, "run_press");
    guard = 0;
    while (m_count < 32'd10 && guard < 200) begin
      tick("free_run");
      guard++;
    end
    check_output("free_run.ten_periods", Cycle_Count, 32'd10);

    repeat ($urandom_range(0, 7)) tick("free_run_extra");
    apply_stimulus(1'b1, 1'b0, "run_halt");
    wait_halt(20, "run_halt");

    // Halt_Request raised one cycle after a falling tick
    apply_stimulus(1'b1, 1'b0, "hreq_run");
    guard = 0;
    while (!(m_mode == M_RUN && ((g_edge - m_entry) % 8) == 4) && guard < 20) begin
      tick("hreq_wait_fall");
      guard++;
    end
    tick("hreq_after_fall");
    Halt_Request = 1'b1;
    h = g_edge;
    wait_halt(12, "hreq");
    check_output("hreq.latency", 32'(g_edge - h), 32'd3);
    apply_stimulus(1'b1, 1'b0, "run_blocked");
    repeat (4) tick("run_blocked_idle");
    check_output("run_blocked.state", 32'(State), 32'd0);
    Halt_Request = 1'b0;
    tick("hreq_drop");

    // Both buttons together: run wins
    apply_stimulus(1'b1, 1'b1, "both");
    check_output("both.state_run", 32'(State), 32'd1);
    apply_stimulus(1'b1, 1'b0, "both_halt");
    wait_halt(20, "both_halt");

    // Reset mid-run while Slow_Clock is low
    apply_stimulus(1'b1, 1'b0, "reset_run");
    guard = 0;
    while (!(m_mode == M_RUN && ((g_edge - m_entry) % 8) >= 4) && guard < 20) begin
      tick("reset_wait_low");
      guard++;
    end
    check_output("reset_run.slow_low", 32'(Slow_Clock), 32'd0);
    async_reset("reset_mid_run");
    repeat (3) tick("reset_quiet");

    // Single step with DIV=2 and a second step press ignored during STEP
    load_div(2);
    Step_Button = 1'b1;
    m_step_at   = g_edge + 3;
    repeat (2) tick("step");
    Step_Button = 1'b0;
    repeat (2) tick("step");
    Step_Button = 1'b1;
    m_step_at   = g_edge + 3;
    repeat (2) tick("step_again");
    Step_Button = 1'b0;
    wait_halt(20, "step");
    repeat (6) tick("step_after");
    check_output("step.one_enable", Cycle_Count, 32'd1);
    check_output("step.slow_rest", 32'(Slow_Clock), 32'd1);

    // Live divider change: DIV=2500, load 10 at count 100
    async_reset("reset_live");
    apply_stimulus(1'b1, 1'b0, "live_run");
    guard = 0;
    while ((g_edge - m_entry) < 100 && guard < 200) begin
      tick("live_wait");
      guard++;
    end
    Div_Load  = 1'b1;
    Div_Value = DIV_W'(10);
    tick("live_load");
    Div_Load  = 1'b0;
    m_div     = 10;
    m_entry   = g_edge - 10;
    cnt = 0;
    while (Cpu_Enable !== 1'b1 && cnt < 40) begin
      tick("live_next");
      cnt++;
    end
    check_output("live.rise_delay", 32'(cnt), 32'd12);

    // Cycle_Count wrap
    guard = 0;
    while (!(m_mode == M_RUN && ((g_edge - m_entry) % 22) == 11) && guard < 30) begin
      tick("wrap_wait_fall");
      guard++;
    end
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    tick("wrap_force");
    release dut.cycle_count_q;
    guard = 0;
    while (Cpu_Enable !== 1'b1 && guard < 30) begin
      tick("wrap_run");
      guard++;
    end
    check_output("wrap.zero", Cycle_Count, 32'd0);
    Halt_Request = 1'b1;
    tick("wrap_halt_req");
    Halt_Request = 1'b0;
    wait_halt(30, "wrap_halt");

    // Randomized runs and steps over small dividers, including zero
    for (int it = 0; it < 8; it++) begin
      d = $urandom_range(0, 4);
      load_div(d);
      if ($urandom_range(0, 1) == 1) begin
        apply_stimulus(1'b0, 1'b1, "rand_step");
        wait_halt(4 * (d + 1) + 8, "rand_step");
      end else begin
        apply_stimulus(1'b1, 1'b0, "rand_run");
        repeat ($urandom_range(0, 20)) begin
          Halt_Request = ($urandom_range(0, 9) == 0);
          tick("rand_run");
        end
        Halt_Request = 1'b0;
        if (m_mode != M_HALT) begin
          Halt_Request = 1'b1;
          tick("rand_halt_req");
          Halt_Request = 1'b0;
        end
        wait_halt(4 * (d + 1) + 8, "rand_run");
      end
      repeat (2) tick("rand_idle");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
